// File: rtl/reset_sequencer.sv
// SoC reset tree: synchronises PLL locks, debounces the pushbutton and
// releases PORESETn then SYSRESETn in order, tracking the last reset cause.
module reset_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 48000,
    parameter int POR_CYCLES      = 15,
    parameter int SYS_CYCLES      = 8
) (
    input  logic       hclk,
    input  logic       RESET,
    input  logic       hpll_lock_i,
    input  logic       tpll_lock_i,
    input  logic       btn_i,
    input  logic       sw_req_i,
    output logic       poreset_n,
    output logic       sysreset_n,
    output logic [2:0] state_o,
    output logic [1:0] cause_o
);

    typedef enum logic [2:0] {
        S_ASSERT   = 3'd0,
        S_POR_WAIT = 3'd1,
        S_SYS_WAIT = 3'd2,
        S_RUN      = 3'd3,
        S_SYSRST   = 3'd4
    } state_t;

    localparam int MAXC = (POR_CYCLES > SYS_CYCLES) ? POR_CYCLES : SYS_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CW-1:0] CNT_MAX  = CW'(MAXC);
    localparam logic [CW-1:0] POR_LAST = CW'(POR_CYCLES - 1);
    localparam logic [CW-1:0] SYS_LAST = CW'(SYS_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] hsync;
    logic [SYNC_STAGES-1:0] tsync;
    logic [SYNC_STAGES-1:0] bsync;
    logic                   lock_h;
    logic                   lock_t;
    logic                   btn_s;

    logic [DW-1:0]          db_cnt;
    logic                   btn_db;

    logic                   lock_ok;
    logic                   ok;

    state_t                 state;
    state_t                 state_d;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_d;
    logic [CW-1:0]          cnt_inc;
    logic [1:0]             cause_d;

    // Multi-flop synchronisers for the asynchronous board inputs
    always_ff @(posedge hclk) begin
        if (RESET) begin
            hsync <= '0;
            tsync <= '0;
            bsync <= '0;
        end else begin
            hsync <= {hsync[SYNC_STAGES-2:0], hpll_lock_i};
            tsync <= {tsync[SYNC_STAGES-2:0], tpll_lock_i};
            bsync <= {bsync[SYNC_STAGES-2:0], btn_i};
        end
    end

    assign lock_h = hsync[SYNC_STAGES-1];
    assign lock_t = tsync[SYNC_STAGES-1];
    assign btn_s  = bsync[SYNC_STAGES-1];

    // Button debouncer: flip only after a full run of differing samples
    always_ff @(posedge hclk) begin
        if (RESET) begin
            db_cnt <= '0;
            btn_db <= 1'b0;
        end else if (btn_s == btn_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_cnt <= '0;
            btn_db <= ~btn_db;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign lock_ok = lock_h & lock_t;
    assign ok      = lock_ok & ~btn_db;
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    // Next-state logic; a fault restarts the whole release sequence
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        cause_d = cause_o;
        if (!ok) begin
            state_d = S_ASSERT;
            cnt_d   = '0;
            if (state != S_ASSERT) begin
                cause_d = lock_ok ? 2'd2 : 2'd1;
            end
        end else begin
            unique case (state)
                S_ASSERT: begin
                    state_d = S_POR_WAIT;
                    cnt_d   = '0;
                end
                S_POR_WAIT: begin
                    if (cnt == POR_LAST) begin
                        state_d = S_SYS_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_SYS_WAIT: begin
                    if (cnt == SYS_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_RUN: begin
                    if (sw_req_i) begin
                        state_d = S_SYSRST;
                        cnt_d   = '0;
                        cause_d = 2'd3;
                    end
                end
                S_SYSRST: begin
                    if (cnt == SYS_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = S_ASSERT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State register with outputs registered as a decode of the next state
    always_ff @(posedge hclk) begin
        if (RESET) begin
            state      <= S_ASSERT;
            cnt        <= '0;
            cause_o    <= 2'd0;
            poreset_n  <= 1'b0;
            sysreset_n <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            cause_o    <= cause_d;
            poreset_n  <= (state_d == S_SYS_WAIT) ||
                          (state_d == S_RUN) ||
                          (state_d == S_SYSRST);
            sysreset_n <= (state_d == S_RUN);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed release/fault scenarios plus random
// input traffic, checked each cycle against a timeline model of the tree.
module tb_reset_sequencer;

    localparam int SYNC = 2;
    localparam int DB   = 40;
    localparam int P    = 15;
    localparam int S    = 8;

    logic       hclk;
    logic       RESET;
    logic       hpll_lock_i;
    logic       tpll_lock_i;
    logic       btn_i;
    logic       sw_req_i;
    logic       poreset_n;
    logic       sysreset_n;
    logic [2:0] state_o;
    logic [1:0] cause_o;

    int vectors;
    int miscompares;

    reset_sequencer #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DB),
        .POR_CYCLES     (P),
        .SYS_CYCLES     (S)
    ) dut (
        .hclk       (hclk),
        .RESET      (RESET),
        .hpll_lock_i(hpll_lock_i),
        .tpll_lock_i(tpll_lock_i),
        .btn_i      (btn_i),
        .sw_req_i   (sw_req_i),
        .poreset_n  (poreset_n),
        .sysreset_n (sysreset_n),
        .state_o    (state_o),
        .cause_o    (cause_o)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: sync histories, debounce run length, and the number of
    // consecutive fault-free edges since the tree last collapsed.
    bit [SYNC-1:0] m_h, m_t, m_b;
    bit            m_db;
    int            m_drun;
    int            m_up;
    int            m_swrem;
    int            m_cause;
    bit            m_init;

    initial begin
        m_init = 0;
        forever begin
            @(posedge hclk);
            if (RESET) begin
                m_h = '0; m_t = '0; m_b = '0;
                m_db = 0; m_drun = 0;
                m_up = 0; m_swrem = 0; m_cause = 0;
                m_init = 1;
            end else begin
                bit lock, ok;
                lock = m_h[SYNC-1] & m_t[SYNC-1];
                ok   = lock & !m_db;
                if (!ok) begin
                    if (m_up > 0) m_cause = lock ? 2 : 1;
                    m_up = 0;
                    m_swrem = 0;
                end else begin
                    if (m_swrem > 0) m_swrem--;
                    else if (m_up >= 1 + P + S && sw_req_i) begin
                        m_swrem = S;
                        m_cause = 3;
                    end
                    if (m_up < 1000) m_up++;
                end
                if (m_b[SYNC-1] != m_db) begin
                    m_drun++;
                    if (m_drun == DB) begin
                        m_db = !m_db;
                        m_drun = 0;
                    end
                end else begin
                    m_drun = 0;
                end
                m_h = {m_h[SYNC-2:0], hpll_lock_i};
                m_t = {m_t[SYNC-2:0], tpll_lock_i};
                m_b = {m_b[SYNC-2:0], btn_i};
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge hclk) begin
        if (m_init) begin
            int es;
            es = (m_up == 0) ? 0 :
                 (m_up < 1 + P) ? 1 :
                 (m_up < 1 + P + S) ? 2 :
                 (m_swrem > 0) ? 4 : 3;
            check("cyc_poreset_n", int'(poreset_n), int'(m_up >= 1 + P));
            check("cyc_sysreset_n", int'(sysreset_n),
                  int'(m_up >= 1 + P + S && m_swrem == 0));
            check("cyc_state", int'(state_o), es);
            check("cyc_cause", int'(cause_o), m_cause);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge hclk);
            #2;
        end
    endtask

    initial begin
        int por_at, sys_at, lat, lowc, porlow, left;
        vectors = 0;
        miscompares = 0;
        RESET = 1; hpll_lock_i = 1; tpll_lock_i = 1;
        btn_i = 0; sw_req_i = 0;
        cyc(3);

        // 1: clean power-up release timing
        check("rst_por", int'(poreset_n), 0);
        check("rst_sys", int'(sysreset_n), 0);
        check("rst_state", int'(state_o), 0);
        RESET = 0;
        por_at = 0; sys_at = 0;
        for (int n = 1; n <= 60; n++) begin
            cyc(1);
            if (poreset_n && por_at == 0) por_at = n;
            if (sysreset_n && sys_at == 0) sys_at = n;
        end
        check("por_release_edge", por_at, 18);
        check("sys_release_edge", sys_at, 26);
        check("cause_after_power", int'(cause_o), 0);

        // 2: one-cycle HCLK PLL drop
        hpll_lock_i = 0;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            cyc(1);
            if (n == 1) hpll_lock_i = 1;
            if (!poreset_n && !sysreset_n && lat == 0) lat = n;
        end
        check("lock_loss_latency", lat, 3);
        check("cause_pll", int'(cause_o), 1);
        cyc(20);
        check("relock_por", int'(poreset_n), 1);
        check("relock_sys", int'(sysreset_n), 1);

        // 3: button bounce then steady press and release
        lowc = 0;
        for (int k = 0; k < 4; k++) begin
            btn_i = 1;
            for (int n = 0; n < 10; n++) begin cyc(1); if (!sysreset_n) lowc++; end
            btn_i = 0;
            for (int n = 0; n < 10; n++) begin cyc(1); if (!sysreset_n) lowc++; end
        end
        cyc(5);
        check("bounce_no_reset", lowc, 0);
        btn_i = 1;
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            cyc(1);
            if (!poreset_n && lat == 0) lat = n;
        end
        check("press_latency", lat, 43);
        check("cause_button", int'(cause_o), 2);
        btn_i = 0;
        sys_at = 0;
        for (int n = 1; n <= 100; n++) begin
            cyc(1);
            if (sysreset_n && sys_at == 0) sys_at = n;
        end
        check("release_sys_edge", sys_at, 66);

        // 4: software system reset width
        sw_req_i = 1;
        lowc = 0; porlow = 0;
        for (int n = 1; n <= 20; n++) begin
            cyc(1);
            if (n == 1) sw_req_i = 0;
            if (!sysreset_n) lowc++;
            if (!poreset_n) porlow++;
        end
        check("sw_low_cycles", lowc, 8);
        check("sw_por_held", porlow, 0);
        check("cause_sw", int'(cause_o), 3);
        RESET = 1;
        cyc(2);
        RESET = 0;
        cyc(5);
        check("por_wait_state", int'(state_o), 1);
        sw_req_i = 1;
        cyc(1);
        sw_req_i = 0;
        cyc(30);
        check("sw_ignored_cause", int'(cause_o), 0);
        check("sw_ignored_sys", int'(sysreset_n), 1);

        // 5: sw request racing a transport PLL loss, then RESET mid-wait
        sw_req_i = 1; tpll_lock_i = 0;
        cyc(1);
        sw_req_i = 0;
        cyc(5);
        check("race_state", int'(state_o), 0);
        check("race_cause", int'(cause_o), 1);
        tpll_lock_i = 1;
        cyc(6);
        check("mid_por_state", int'(state_o), 1);
        RESET = 1;
        cyc(1);
        check("mid_rst_por", int'(poreset_n), 0);
        check("mid_rst_sys", int'(sysreset_n), 0);
        check("mid_rst_cause", int'(cause_o), 0);
        RESET = 0;
        cyc(40);

        // Random traffic
        left = 0;
        for (int n = 0; n < 20000; n++) begin
            RESET       = ($urandom_range(0, 2999) == 0);
            hpll_lock_i = ($urandom_range(0, 599) != 0);
            tpll_lock_i = ($urandom_range(0, 599) != 0);
            sw_req_i    = ($urandom_range(0, 39) == 0);
            if (left > 0) begin
                left--;
                btn_i = ($urandom_range(0, 7) != 0);
            end else begin
                btn_i = 0;
                if ($urandom_range(0, 699) == 0) left = $urandom_range(1, 100);
            end
            cyc(1);
        end
        RESET = 0; hpll_lock_i = 1; tpll_lock_i = 1;
        btn_i = 0; sw_req_i = 0;
        cyc(120);
        check("final_sys", int'(sysreset_n), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
